alu_byte_serial_ctrl: RTL and testbench

//   Multi-byte arithmetic sequencer wrapped around the 8-bit ALU datapath (alu_8bit / cla_8bit).

---
 rtl/alu_byte_serial_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_byte_serial_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_byte_serial_ctrl.sv
// Byte-serial multi-byte arithmetic sequencer driving an external 8-bit ALU.
// Processes an NBYTES-wide operation LSB first, chaining the ALU carry between bytes.
module alu_byte_serial_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic [1:0]          req_op,
  input  logic                req_cin,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_s1,
  output logic                alu_s0,
  output logic                alu_cin,
  input  logic [7:0]          alu_f,
  input  logic                alu_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_result,
  output logic                rsp_cout,
  output logic                rsp_zero,
  output logic                busy
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [NBYTES-1:0][7:0]     a_q, a_d;
  logic [NBYTES-1:0][7:0]     b_q, b_d;
  logic [NBYTES-1:0][7:0]     result_q, result_d;
  logic [1:0]                 op_q, op_d;
  logic                       carry_q, carry_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       rsp_cout_q, rsp_cout_d;
  logic                       req_ready_q, req_ready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      rsp_cout_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      rsp_cout_q  <= rsp_cout_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, byte sequencing and ALU drive
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    op_d       = op_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    rsp_cout_d = rsp_cout_q;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_s1     = 1'b0;
    alu_s0     = 1'b0;
    alu_cin    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d      = req_a;
          b_d      = req_b;
          op_d     = req_op;
          carry_d  = req_cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        alu_a            = a_q[idx_q];
        alu_b            = b_q[idx_q];
        alu_s1           = op_q[1];
        alu_s0           = op_q[0];
        alu_cin          = carry_q;
        result_d[idx_q]  = alu_f;
        carry_d          = alu_cout;
        idx_d            = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          rsp_cout_d = alu_cout;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags track the state being entered so they stay flop outputs
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;
  assign rsp_result = result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_byte_serial_ctrl.sv
// Bench for alu_byte_serial_ctrl: behavioural 8-bit ALU on the alu_* port and a
// full-width arithmetic reference for every operation.
module tb_alu_byte_serial_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_op;
  logic         req_cin;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_s1;
  logic         alu_s0;
  logic         alu_cin;
  logic [7:0]   alu_f;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         busy;

  int n_tests;
  int n_fail;

  alu_byte_serial_ctrl #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_cin    (req_cin),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s1     (alu_s1),
    .alu_s0     (alu_s0),
    .alu_cin    (alu_cin),
    .alu_f      (alu_f),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational 8-bit ALU
  always_comb begin
    logic [8:0] s;
    case ({alu_s1, alu_s0})
      2'b00:   s = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      2'b01:   s = {1'b0, alu_a} + 9'(alu_cin);
      2'b10:   s = {1'b0, ~alu_b} + 9'(alu_cin);
      default: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'(alu_cin);
    endcase
    alu_f    = s[7:0];
    alu_cout = s[8];
  end

  // Whole-word reference: {cout, result}
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op, input logic cin);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      2'b01:   return {1'b0, a} + (W+1)'(cin);
      2'b10:   return {1'b0, ~b} + (W+1)'(cin);
      default: return {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation with rsp_ready held high; checks latency, result and handshake
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic cin);
    logic [W:0] exp;
    int lat;
    exp = ref_op(a, b, op, cin);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = a; req_b = b; req_op = op; req_cin = cin;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_alu_a0"}, 32'(alu_a), 32'(a[7:0]));
    lat = 0;
    while (!rsp_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NB));
    chk({tag, "_result"}, 32'(rsp_result), 32'(exp[W-1:0]));
    chk({tag, "_cout"}, 32'(rsp_cout), 32'(exp[W]));
    chk({tag, "_zero"}, 32'(rsp_zero), 32'(exp[W-1:0] == '0));
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, rsp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    logic [W:0]   exp1, exp2;
    logic [W-1:0] held;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0; req_b = '0; req_op = 2'b00; req_cin = 1'b0;
    rsp_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd1);
    chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_alu", {alu_a, alu_b, 5'd0, alu_s1, alu_s0, alu_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner operations
    run_op("add_carry", 32'h0000_00FF, 32'h0000_0001, 2'b00, 1'b0);
    run_op("sub_borrow", 32'h0000_0000, 32'h0000_0001, 2'b11, 1'b1);
    run_op("sub_equal", 32'h1234_5678, 32'h1234_5678, 2'b11, 1'b1);
    run_op("inc_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 2'b01, 1'b1);
    run_op("negate", 32'hDEAD_BEEF, 32'h0000_0005, 2'b10, 1'b1);

    // Backpressure in DONE, with a request pulse that must be ignored
    exp1 = ref_op(32'hA5A5_0F0F, 32'h1111_2222, 2'b00, 1'b1);
    exp2 = ref_op(32'h8000_0001, 32'h0000_0003, 2'b11, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_a = 32'hA5A5_0F0F; req_b = 32'h1111_2222; req_op = 2'b00; req_cin = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (NB) @(posedge clk);
    #1;
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_result", 32'(rsp_result), 32'(exp1[W-1:0]));
    held = rsp_result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = (i == 1);
      req_a = 32'h8000_0001; req_b = 32'h0000_0003; req_op = 2'b11; req_cin = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_result", 32'(rsp_result), 32'(held));
      chk("bp_hold_cout", 32'(rsp_cout), 32'(exp1[W]));
      chk("bp_hold_flags", {29'd0, rsp_valid, req_ready, busy}, 32'b101);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake", {29'd0, rsp_valid, req_ready, busy}, 32'b010);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_accept_next", {30'd0, req_ready, busy}, 32'b01);
    repeat (NB) @(posedge clk);
    #1;
    chk("bp_second_valid", 32'(rsp_valid), 32'd1);
    chk("bp_second_result", 32'(rsp_result), 32'(exp2[W-1:0]));
    chk("bp_second_cout", 32'(rsp_cout), 32'(exp2[W]));
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts the operation
    @(negedge clk);
    req_valid = 1'b1;
    req_a = 32'h3344_5566; req_b = 32'h7788_99AA; req_op = 2'b00; req_cin = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_byte2", 32'(alu_a), 32'h44);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {29'd0, rsp_valid, req_ready, busy}, 32'b010);
    chk("abort_alu", {alu_a, alu_b, 5'd0, alu_s1, alu_s0, alu_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NB + 1) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    run_op("after_abort", 32'h0101_0101, 32'h0101_0101, 2'b00, 1'b0);

    // Randomised operations against the whole-word reference
    for (int i = 0; i < 24; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
